// File: rtl/pixel_threshold_if.sv
// Pixel stream bundle for the threshold pipe.
// Master drives the input beat and receives the processed beat.
interface pixel_threshold_if #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 16,
  parameter int GRAY_W = 8
);
  logic                     iValid;
  logic                     iSOF;
  logic                     iEOF;
  logic [NUM_CH*DATA_W-1:0] iData;
  logic [GRAY_W-1:0]        iGray;
  logic                     oValid;
  logic                     oSOF;
  logic                     oEOF;
  logic [NUM_CH*DATA_W-1:0] oData;

  modport master (
    output iValid, iSOF, iEOF, iData, iGray,
    input  oValid, oSOF, oEOF, oData
  );

  modport slave (
    input  iValid, iSOF, iEOF, iData, iGray,
    output oValid, oSOF, oEOF, oData
  );
endinterface

// File: rtl/pixel_threshold_pipe.sv
// Two-stage streaming binariser with frame-latched controls,
// hysteresis mode and per-frame mean gray measurement.
module pixel_threshold_pipe #(
  parameter int NUM_CH   = 2,
  parameter int DATA_W   = 16,
  parameter int GRAY_W   = 8,
  parameter int LOG2_PIX = 19
) (
  input  logic              iCLK,
  input  logic              iRST,
  pixel_threshold_if.slave  pix,
  input  logic              iEnable,
  input  logic [1:0]        iMode,
  input  logic [GRAY_W-1:0] iThreshold,
  input  logic [GRAY_W-1:0] iThreshLo,
  output logic [GRAY_W-1:0] oFrameMean,
  output logic              oMeanValid
);

  localparam int DW    = NUM_CH * DATA_W;
  localparam int ACC_W = GRAY_W + LOG2_PIX;

  typedef enum logic [1:0] {
    MODE_BIN  = 2'd0,
    MODE_INV  = 2'd1,
    MODE_HYST = 2'd2,
    MODE_MEAN = 2'd3
  } mode_e;

  logic              s1Valid;
  logic              s1Sof;
  logic              s1Eof;
  logic [DW-1:0]     s1Data;
  logic [GRAY_W-1:0] s1Gray;

  logic              ctlEnable;
  mode_e             ctlMode;
  logic [GRAY_W-1:0] ctlThr;
  logic [GRAY_W-1:0] ctlLo;

  logic              hyst;
  logic [ACC_W-1:0]  acc;

  logic              hit;
  logic              hPrev;
  logic              hNext;
  logic              bitOut;
  logic [DW-1:0]     dataNext;
  logic [ACC_W:0]    sum;
  logic [ACC_W-1:0]  accNext;
  logic [GRAY_W-1:0] meanNext;

  always_comb begin
    hit   = s1Gray >= ctlThr;
    hPrev = s1Sof ? 1'b0 : hyst;
    hNext = hPrev;
    // set wins over clear when the low level sits above the high level
    if (hit)
      hNext = 1'b1;
    else if (s1Gray < ctlLo)
      hNext = 1'b0;

    bitOut = hit;
    unique case (ctlMode)
      MODE_BIN:  bitOut = hit;
      MODE_INV:  bitOut = !hit;
      MODE_HYST: bitOut = hNext;
      MODE_MEAN: bitOut = hit;
      default:   bitOut = hit;
    endcase

    dataNext = ctlEnable ? {DW{bitOut}} : s1Data;

    sum     = (ACC_W+1)'(acc) + (ACC_W+1)'(s1Gray);
    accNext = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    if (s1Sof)
      accNext = ACC_W'(s1Gray);
    meanNext = GRAY_W'(accNext >> LOG2_PIX);
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      s1Valid    <= 1'b0;
      s1Sof      <= 1'b0;
      s1Eof      <= 1'b0;
      s1Data     <= '0;
      s1Gray     <= '0;
      ctlEnable  <= 1'b0;
      ctlMode    <= MODE_BIN;
      ctlThr     <= '0;
      ctlLo      <= '0;
      hyst       <= 1'b0;
      acc        <= '0;
      pix.oValid <= 1'b0;
      pix.oSOF   <= 1'b0;
      pix.oEOF   <= 1'b0;
      pix.oData  <= '0;
      oFrameMean <= '0;
      oMeanValid <= 1'b0;
    end else begin
      s1Valid <= pix.iValid;
      s1Sof   <= pix.iValid & pix.iSOF;
      s1Eof   <= pix.iValid & pix.iEOF;
      if (pix.iValid) begin
        s1Data <= pix.iData;
        s1Gray <= pix.iGray;
      end

      // SOF beat carries the new controls into stage 2 one edge later
      if (pix.iValid && pix.iSOF) begin
        ctlEnable <= iEnable;
        ctlMode   <= mode_e'(iMode);
        ctlThr    <= (iMode == 2'd3) ? oFrameMean : iThreshold;
        ctlLo     <= iThreshLo;
      end

      pix.oValid <= s1Valid;
      pix.oSOF   <= s1Sof;
      pix.oEOF   <= s1Eof;
      oMeanValid <= s1Valid & s1Eof;

      if (s1Valid) begin
        pix.oData <= dataNext;
        hyst      <= hNext;
        acc       <= accNext;
        if (s1Eof)
          oFrameMean <= meanNext;
      end
    end
  end

endmodule

// File: tb/tb_pixel_threshold_pipe.sv
// Scoreboard bench for pixel_threshold_pipe with LOG2_PIX=2.
// Directed frames push hand-computed beats and means; a monitor checks them.
module tb_pixel_threshold_pipe;

  localparam logic [31:0] D0   = 32'h1234ABCD;
  localparam logic [31:0] ONES = 32'hFFFFFFFF;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en;
  logic [1:0] mode;
  logic [7:0] thr;
  logic [7:0] lo;
  logic [7:0] frameMean;
  logic       meanValid;

  pixel_threshold_if #(.NUM_CH(2), .DATA_W(16), .GRAY_W(8)) pix();

  pixel_threshold_pipe #(
    .NUM_CH(2), .DATA_W(16), .GRAY_W(8), .LOG2_PIX(2)
  ) dut (
    .iCLK(clk),
    .iRST(rst),
    .pix(pix),
    .iEnable(en),
    .iMode(mode),
    .iThreshold(thr),
    .iThreshLo(lo),
    .oFrameMean(frameMean),
    .oMeanValid(meanValid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        sof;
    logic        eof;
    int          cyc;
  } exp_t;

  exp_t       expQ[$];
  logic [7:0] meanQ[$];
  exp_t       e;
  logic [7:0] m;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic ok,
                     input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (pix.oValid) begin
        chk("beatExpected", expQ.size() != 0, 64'(pix.oData), 0);
        if (expQ.size() != 0) begin
          e = expQ.pop_front();
          chk("data", pix.oData === e.data, 64'(pix.oData), 64'(e.data));
          chk("sofEof", {pix.oSOF, pix.oEOF} === {e.sof, e.eof},
              64'({pix.oSOF, pix.oEOF}), 64'({e.sof, e.eof}));
          chk("latency", cyc == e.cyc, 64'(cyc), 64'(e.cyc));
        end
      end
      if (meanValid) begin
        chk("meanWithEof", pix.oValid && pix.oEOF,
            64'({pix.oValid, pix.oEOF}), 64'(2'b11));
        chk("meanExpected", meanQ.size() != 0, 64'(frameMean), 0);
        if (meanQ.size() != 0) begin
          m = meanQ.pop_front();
          chk("frameMean", frameMean === m, 64'(frameMean), 64'(m));
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    pix.iValid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic setCtl(input logic e1, input logic [1:0] m1,
                        input logic [7:0] t1, input logic [7:0] l1);
    en   = e1;
    mode = m1;
    thr  = t1;
    lo   = l1;
  endtask

  task automatic beat(input logic sof, input logic eof, input logic [7:0] g,
                      input logic [31:0] d, input logic [31:0] want);
    pix.iValid = 1'b1;
    pix.iSOF   = sof;
    pix.iEOF   = eof;
    pix.iGray  = g;
    pix.iData  = d;
    expQ.push_back('{want, sof, eof, cyc + 2});
    tick();
    pix.iValid = 1'b0;
    pix.iSOF   = 1'b0;
    pix.iEOF   = 1'b0;
  endtask

  initial begin
    pix.iValid = 1'b0;
    pix.iSOF   = 1'b0;
    pix.iEOF   = 1'b0;
    pix.iGray  = '0;
    pix.iData  = '0;
    setCtl(1'b0, 2'd0, 8'h00, 8'h00);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("resetCtl", {pix.oValid, pix.oSOF, pix.oEOF, meanValid} == 4'b0,
        64'({pix.oValid, pix.oSOF, pix.oEOF, meanValid}), 0);
    chk("resetData", pix.oData == 32'h0 && frameMean == 8'h0,
        {24'h0, frameMean, pix.oData}, 0);
    tick();
    rst = 1'b0;
    tick();

    // bypass
    setCtl(1'b0, 2'd0, 8'h00, 8'h00);
    beat(1, 0, 8'd10, D0, D0);
    beat(0, 0, 8'd20, 32'h5555AAAA, 32'h5555AAAA);
    beat(0, 0, 8'd30, 32'h00FF0F0F, 32'h00FF0F0F);
    meanQ.push_back(8'd25);
    beat(0, 1, 8'd40, 32'hDEADBEEF, 32'hDEADBEEF);
    idle(3);

    // binary, mid-frame mode change ignored
    setCtl(1'b1, 2'd0, 8'h80, 8'h00);
    beat(1, 0, 8'h7F, D0, 32'h0);
    setCtl(1'b1, 2'd1, 8'h10, 8'h00);
    beat(0, 0, 8'h80, D0, ONES);
    meanQ.push_back(8'd127);
    beat(0, 1, 8'hFF, D0, ONES);
    idle(3);

    // inverted
    setCtl(1'b1, 2'd1, 8'h80, 8'h00);
    beat(1, 0, 8'h7F, D0, ONES);
    beat(0, 0, 8'h80, D0, 32'h0);
    meanQ.push_back(8'd127);
    beat(0, 1, 8'hFF, D0, 32'h0);
    idle(3);

    // hysteresis hi=100 lo=50
    setCtl(1'b1, 2'd2, 8'd100, 8'd50);
    beat(1, 0, 8'd60, D0, 32'h0);
    beat(0, 0, 8'd120, D0, ONES);
    beat(0, 0, 8'd80, D0, ONES);
    beat(0, 0, 8'd49, D0, 32'h0);
    meanQ.push_back(8'd94);
    beat(0, 1, 8'd70, D0, 32'h0);
    idle(3);

    // SOF clears h and discards the partial sum
    beat(1, 0, 8'd120, D0, ONES);
    beat(0, 0, 8'd80, D0, ONES);
    beat(1, 0, 8'd70, D0, 32'h0);
    meanQ.push_back(8'd37);
    beat(0, 1, 8'd80, D0, 32'h0);
    idle(3);

    // lo above hi: set wins; also a 1-pixel frame
    setCtl(1'b1, 2'd2, 8'd50, 8'd100);
    meanQ.push_back(8'd17);
    beat(1, 1, 8'd70, D0, ONES);
    idle(3);

    // mean of 10,20,30,40 then mode 3 against it
    setCtl(1'b0, 2'd0, 8'h00, 8'h00);
    beat(1, 0, 8'd10, D0, D0);
    beat(0, 0, 8'd20, D0, D0);
    beat(0, 0, 8'd30, D0, D0);
    meanQ.push_back(8'd25);
    beat(0, 1, 8'd40, D0, D0);
    idle(3);
    setCtl(1'b1, 2'd3, 8'h00, 8'h00);
    beat(1, 0, 8'd24, D0, 32'h0);
    meanQ.push_back(8'd12);
    beat(0, 1, 8'd25, D0, ONES);
    idle(3);

    // 1-pixel frame then saturating accumulator
    setCtl(1'b0, 2'd0, 8'h00, 8'h00);
    meanQ.push_back(8'd50);
    beat(1, 1, 8'd200, D0, D0);
    idle(3);
    beat(1, 0, 8'hFF, D0, D0);
    beat(0, 0, 8'hFF, D0, D0);
    beat(0, 0, 8'hFF, D0, D0);
    beat(0, 0, 8'hFF, D0, D0);
    meanQ.push_back(8'd255);
    beat(0, 1, 8'hFF, D0, D0);
    idle(4);

    // reset while two beats are in flight
    setCtl(1'b1, 2'd0, 8'h80, 8'h00);
    pix.iValid = 1'b1;
    pix.iSOF   = 1'b1;
    pix.iGray  = 8'hFF;
    pix.iData  = D0;
    tick();
    pix.iSOF = 1'b0;
    rst      = 1'b1;
    tick();
    rst        = 1'b0;
    pix.iValid = 1'b0;
    @(negedge clk);
    chk("flushValid", pix.oValid == 1'b0, 64'(pix.oValid), 0);
    chk("flushMean", frameMean == 8'h0, 64'(frameMean), 0);
    tick();
    beat(0, 0, 8'h00, D0, D0);
    idle(3);
    setCtl(1'b1, 2'd3, 8'hF0, 8'h00);
    meanQ.push_back(8'd0);
    beat(1, 1, 8'h00, D0, ONES);

    for (int i = 0; i < 20 && (expQ.size() != 0 || meanQ.size() != 0); i++)
      tick();
    chk("drained", expQ.size() == 0 && meanQ.size() == 0,
        64'(expQ.size() + meanQ.size()), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
